// File: rtl/cu_pkg.sv
// Shared types and constants for the control unit: FSM states, opcodes,
// ALU function codes, ARF register indices and the packed control word.
// Optional feature macro used by the importing files: CU_BRANCH_EN.
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_L = 3'd0,
        ST_FETCH_H = 3'd1,
        ST_EXEC1   = 3'd2,
        ST_EXEC2   = 3'd3,
        ST_HALT    = 3'd4
    } cu_state_t;

    // Opcodes, ir_in[15:12]
    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;
    localparam logic [3:0] OP_BRA = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU function selects
    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1010;

    // Register function selects (IR, ARF, RF)
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    // ARF register indices; one-hot enable bit is 3-index (AR -> 1000, PC -> 0001)
    localparam int ARF_AR  = 0;
    localparam int ARF_SP  = 1;
    localparam int ARF_PCP = 2;
    localparam int ARF_PC  = 3;

    typedef struct packed {
        logic [1:0] funsel_ir;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] rf_tsel;
        logic [3:0] regsel_arf;
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] mux_sel_a;
        logic [1:0] mux_sel_b;
        logic       mux_sel_c;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic       wr_mem;
        logic       cs_mem;
        logic       ir_enable;
        logic       ir_lh;
        logic       halted;
    } cu_ctrl_t;

    // Idle control word: nothing enabled, memory deselected (csMEM active-low)
    function automatic cu_ctrl_t idle_ctrl();
        cu_ctrl_t c;
        c        = '0;
        c.cs_mem = 1'b1;
        return c;
    endfunction

    function automatic logic [3:0] arf_sel(input int idx);
        return 4'b1000 >> idx;
    endfunction

    // RF write enable for Rd: dst 0 -> 1000 ... dst 3 -> 0001
    function automatic logic [3:0] rf_dst_sel(input logic [1:0] r);
        return 4'b1000 >> r;
    endfunction

    // RF read select: Rn appears at 4+n on the output muxes
    function automatic logic [2:0] rf_read_sel(input logic [1:0] r);
        return {1'b1, r};
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of FSM state and instruction fields into the
// datapath control word. Branch opcodes A-C are decoded only when
// CU_BRANCH_EN is defined; otherwise they fall through as NOPs and the
// zflag input does not exist.
module cu_decode
    import cu_pkg::*;
(
    input  cu_state_t  state,
    input  logic [3:0] opcode,
    input  logic [1:0] dst,
    input  logic [1:0] src,
`ifdef CU_BRANCH_EN
    input  logic       zflag,
`endif
    output cu_ctrl_t   ctrl
);

    // Map state and opcode to the control word
    always_comb begin
        // NOTE: start from the idle word so every field is assigned on every path; no latches.
        ctrl = idle_ctrl();
        case (state)
            ST_FETCH_L, ST_FETCH_H: begin
                ctrl.outbsel    = 2'd3;
                ctrl.cs_mem     = 1'b0;
                ctrl.ir_enable  = 1'b1;
                ctrl.ir_lh      = (state == ST_FETCH_H);
                ctrl.funsel_ir  = FUN_LOAD;
                ctrl.regsel_arf = arf_sel(ARF_PC);
                ctrl.funsel_arf = FUN_INC;
            end
            ST_EXEC1: begin
                case (opcode)
                    OP_LDI: begin
                        ctrl.mux_sel_a = 2'd2;
                        ctrl.funsel_rf = FUN_LOAD;
                        ctrl.regsel_rf = rf_dst_sel(dst);
                    end
                    OP_LD, OP_ST: begin
                        ctrl.mux_sel_b  = 2'd2;
                        ctrl.regsel_arf = arf_sel(ARF_AR);
                        ctrl.funsel_arf = FUN_LOAD;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        ctrl.rf_o1sel  = rf_read_sel(dst);
                        ctrl.rf_o2sel  = rf_read_sel(src);
                        ctrl.mux_sel_c = 1'b0;
                        ctrl.mux_sel_a = 2'd0;
                        ctrl.funsel_rf = FUN_LOAD;
                        ctrl.regsel_rf = rf_dst_sel(dst);
                        case (opcode)
                            OP_ADD:  ctrl.funsel_alu = ALU_ADD;
                            OP_SUB:  ctrl.funsel_alu = ALU_SUB;
                            OP_AND:  ctrl.funsel_alu = ALU_AND;
                            OP_OR:   ctrl.funsel_alu = ALU_OR;
                            default: ctrl.funsel_alu = ALU_XOR;
                        endcase
                    end
                    OP_INC, OP_DEC: begin
                        ctrl.regsel_rf = rf_dst_sel(dst);
                        ctrl.funsel_rf = (opcode == OP_INC) ? FUN_INC : FUN_DEC;
                    end
`ifdef CU_BRANCH_EN
                    OP_BRA, OP_BEQ, OP_BNE: begin
                        if ((opcode == OP_BRA) ||
                            (opcode == OP_BEQ &&  zflag) ||
                            (opcode == OP_BNE && !zflag)) begin
                            ctrl.mux_sel_b  = 2'd2;
                            ctrl.regsel_arf = arf_sel(ARF_PC);
                            ctrl.funsel_arf = FUN_LOAD;
                        end
                    end
`endif
                    default: ;  // HLT and NOPs: idle word
                endcase
            end
            ST_EXEC2: begin
                ctrl.outbsel = 2'd0;
                ctrl.cs_mem  = 1'b0;
                if (opcode == OP_LD) begin
                    ctrl.mux_sel_a = 2'd1;
                    ctrl.funsel_rf = FUN_LOAD;
                    ctrl.regsel_rf = rf_dst_sel(dst);
                end else if (opcode == OP_ST) begin
                    ctrl.rf_o1sel   = rf_read_sel(src);
                    ctrl.mux_sel_c  = 1'b0;
                    ctrl.funsel_alu = ALU_PASS;
                    ctrl.wr_mem     = 1'b1;
                end
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: two-byte instruction fetch, one or two execute
// states, and a terminal HALT. Outputs are combinational from state, ir_in
// and zflag, and are forced idle while reset is high.
// Optional feature: define CU_BRANCH_EN to enable BRA/BEQ/BNE and the zflag
// register; without it opcodes A-C are NOPs and zflag does not exist.
module control_unit
    import cu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] ir_in,
    input  logic [3:0]  alu_flag,
    output logic [1:0]  funsel_IR,
    output logic [1:0]  funsel_arf,
    output logic [1:0]  funsel_rf,
    output logic [3:0]  funsel_alu,
    output logic [3:0]  regsel_rf,
    output logic [3:0]  rf_tsel,
    output logic [3:0]  regsel_arf,
    output logic [1:0]  outasel,
    output logic [1:0]  outbsel,
    output logic [1:0]  MUXSelA,
    output logic [1:0]  MUXSelB,
    output logic        MUXSelC,
    output logic [2:0]  rf_o1sel,
    output logic [2:0]  rf_o2sel,
    output logic        wrMEM,
    output logic        csMEM,
    output logic        IR_enable,
    output logic        IR_lh,
    output logic        halted
);

    cu_state_t  state;
    cu_ctrl_t   ctrl_dec;
    cu_ctrl_t   ctrl_out;
    logic [3:0] opcode;
    logic [1:0] dst;
    logic [1:0] src;
`ifdef CU_BRANCH_EN
    logic       zflag;
`endif

    assign opcode = ir_in[15:12];
    assign dst    = ir_in[11:10];
    assign src    = ir_in[9:8];

    // The immediate is consumed by the datapath, and flags other than Z never
    // reach the control unit; fold them into a sink so intent is explicit.
    logic unused_inputs;
    assign unused_inputs = ^{ir_in[7:0], alu_flag};

    // State sequencing and Z-flag capture after ALU instructions
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FETCH_L;
`ifdef CU_BRANCH_EN
            zflag <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            case (state)
                ST_FETCH_L: state <= ST_FETCH_H;
                ST_FETCH_H: state <= ST_EXEC1;
                ST_EXEC1: begin
                    if (opcode == OP_LD || opcode == OP_ST) begin
                        state <= ST_EXEC2;
                    end else if (opcode == OP_HLT) begin
                        state <= ST_HALT;
                    end else begin
                        state <= ST_FETCH_L;
                    end
`ifdef CU_BRANCH_EN
                    if (is_alu_op(opcode)) begin
                        zflag <= alu_flag[3];
                    end
`endif
                end
                ST_EXEC2: state <= ST_FETCH_L;
                ST_HALT:  state <= ST_HALT;
                default:  state <= ST_FETCH_L;
            endcase
        end
    end

    cu_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .dst    (dst),
        .src    (src),
`ifdef CU_BRANCH_EN
        .zflag  (zflag),
`endif
        .ctrl   (ctrl_dec)
    );

    // Reset overrides the decode so the datapath sees no enables while held.
    // NOTE: this gate is combinational on reset; the FSM alone would already show FETCH_L outputs.
    always_comb begin
        ctrl_out = reset ? idle_ctrl() : ctrl_dec;
    end

    assign funsel_IR  = ctrl_out.funsel_ir;
    assign funsel_arf = ctrl_out.funsel_arf;
    assign funsel_rf  = ctrl_out.funsel_rf;
    assign funsel_alu = ctrl_out.funsel_alu;
    assign regsel_rf  = ctrl_out.regsel_rf;
    assign rf_tsel    = ctrl_out.rf_tsel;
    assign regsel_arf = ctrl_out.regsel_arf;
    assign outasel    = ctrl_out.outasel;
    assign outbsel    = ctrl_out.outbsel;
    assign MUXSelA    = ctrl_out.mux_sel_a;
    assign MUXSelB    = ctrl_out.mux_sel_b;
    assign MUXSelC    = ctrl_out.mux_sel_c;
    assign rf_o1sel   = ctrl_out.rf_o1sel;
    assign rf_o2sel   = ctrl_out.rf_o2sel;
    assign wrMEM      = ctrl_out.wr_mem;
    assign csMEM      = ctrl_out.cs_mem;
    assign IR_enable  = ctrl_out.ir_enable;
    assign IR_lh      = ctrl_out.ir_lh;
    assign halted     = ctrl_out.halted;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instruction sequences
// followed by randomized instructions, flags and reset pulses, all compared
// against an instruction-phase reference model.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] ir_in;
    logic [3:0]  alu_flag;
    logic [1:0]  funsel_IR, funsel_arf, funsel_rf;
    logic [3:0]  funsel_alu, regsel_rf, rf_tsel, regsel_arf;
    logic [1:0]  outasel, outbsel, MUXSelA, MUXSelB;
    logic        MUXSelC;
    logic [2:0]  rf_o1sel, rf_o2sel;
    logic        wrMEM, csMEM, IR_enable, IR_lh, halted;

    control_unit dut (
        .clock      (clock),
        .reset      (reset),
        .ir_in      (ir_in),
        .alu_flag   (alu_flag),
        .funsel_IR  (funsel_IR),
        .funsel_arf (funsel_arf),
        .funsel_rf  (funsel_rf),
        .funsel_alu (funsel_alu),
        .regsel_rf  (regsel_rf),
        .rf_tsel    (rf_tsel),
        .regsel_arf (regsel_arf),
        .outasel    (outasel),
        .outbsel    (outbsel),
        .MUXSelA    (MUXSelA),
        .MUXSelB    (MUXSelB),
        .MUXSelC    (MUXSelC),
        .rf_o1sel   (rf_o1sel),
        .rf_o2sel   (rf_o2sel),
        .wrMEM      (wrMEM),
        .csMEM      (csMEM),
        .IR_enable  (IR_enable),
        .IR_lh      (IR_lh),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    logic [41:0] dut_vec;
    assign dut_vec = {funsel_IR, funsel_arf, funsel_rf, funsel_alu, regsel_rf, rf_tsel,
                      regsel_arf, outasel, outbsel, MUXSelA, MUXSelB, MUXSelC,
                      rf_o1sel, rf_o2sel, wrMEM, csMEM, IR_enable, IR_lh, halted};

    // Model phases: which step of the instruction the unit is in
    localparam int PH_FETCH_LO = 0;
    localparam int PH_FETCH_HI = 1;
    localparam int PH_EXEC     = 2;
    localparam int PH_MEM      = 3;
    localparam int PH_HALTED   = 4;
    localparam int PH_RESET    = 5;

    int   m_phase;
    logic m_z;

    // Expected control outputs for a phase, instruction word and Z flag
    function automatic logic [41:0] expect_ctrl(input int ph, input logic [15:0] ir, input logic z);
        logic [1:0] f_ir, f_arf, f_rf, oa, ob, ma, mb;
        logic [3:0] alu, rs_rf, tsel, rs_arf;
        logic       mc, wr, cs, ire, irlh, hlt, take;
        logic [2:0] o1, o2;
        int         op, d, s;
        f_ir = 0; f_arf = 0; f_rf = 0; oa = 0; ob = 0; ma = 0; mb = 0;
        alu = 0; rs_rf = 0; tsel = 0; rs_arf = 0;
        mc = 0; wr = 0; cs = 1; ire = 0; irlh = 0; hlt = 0; o1 = 0; o2 = 0;
        op = int'(ir[15:12]);
        d  = int'(ir[11:10]);
        s  = int'(ir[9:8]);
        take = 0;
        if (ph == PH_FETCH_LO || ph == PH_FETCH_HI) begin
            ob = 3; cs = 0; ire = 1; irlh = (ph == PH_FETCH_HI);
            f_ir = 1; rs_arf = 4'b0001; f_arf = 3;
        end else if (ph == PH_EXEC) begin
            if (op == 0) begin
                ma = 2; f_rf = 1; rs_rf = 4'(8 >> d);
            end else if (op == 1 || op == 2) begin
                mb = 2; rs_arf = 4'b1000; f_arf = 1;
            end else if (op >= 3 && op <= 7) begin
                o1 = 3'(4 + d); o2 = 3'(4 + s); f_rf = 1; rs_rf = 4'(8 >> d);
                case (op)
                    3: alu = 4'd4;
                    4: alu = 4'd6;
                    5: alu = 4'd7;
                    6: alu = 4'd8;
                    default: alu = 4'd10;
                endcase
            end else if (op == 8 || op == 9) begin
                rs_rf = 4'(8 >> d); f_rf = (op == 8) ? 2'd3 : 2'd2;
            end
`ifdef CU_BRANCH_EN
            take = (op == 10) || (op == 11 && z) || (op == 12 && !z);
`else
            take = 1'b0 & z;
`endif
            if (take) begin
                mb = 2; rs_arf = 4'b0001; f_arf = 1;
            end
        end else if (ph == PH_MEM) begin
            ob = 0; cs = 0;
            if (op == 1) begin
                ma = 1; f_rf = 1; rs_rf = 4'(8 >> d);
            end else if (op == 2) begin
                o1 = 3'(4 + s); wr = 1;
            end
        end else if (ph == PH_HALTED) begin
            hlt = 1;
        end
        return {f_ir, f_arf, f_rf, alu, rs_rf, tsel, rs_arf, oa, ob, ma, mb, mc,
                o1, o2, wr, cs, ire, irlh, hlt};
    endfunction

    // Advance the model across one rising edge using the inputs held at that edge
    task automatic model_edge();
        int op;
        op = int'(ir_in[15:12]);
        case (m_phase)
            PH_FETCH_LO: m_phase = PH_FETCH_HI;
            PH_FETCH_HI: m_phase = PH_EXEC;
            PH_EXEC: begin
`ifdef CU_BRANCH_EN
                if (op >= 3 && op <= 7) m_z = alu_flag[3];
`endif
                if (op == 1 || op == 2)  m_phase = PH_MEM;
                else if (op == 15)       m_phase = PH_HALTED;
                else                     m_phase = PH_FETCH_LO;
            end
            PH_MEM:  m_phase = PH_FETCH_LO;
            default: m_phase = PH_HALTED;
        endcase
    endtask

    // One clock cycle, entered and left 1 time unit after a rising edge.
    // The instruction word may change only while fetching (or halted).
    task automatic cycle(input bit force_en, input logic [15:0] forced);
        if (force_en) ir_in = forced;
        else if (m_phase != PH_EXEC && m_phase != PH_MEM) ir_in = 16'($urandom);
        alu_flag = 4'($urandom);
        #2;
        check($sformatf("ctrl ph%0d ir%04h", m_phase, ir_in), dut_vec, expect_ctrl(m_phase, ir_in, m_z));
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Asynchronous reset pulse spanning one rising edge
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("reset_async_idle", dut_vec, expect_ctrl(PH_RESET, ir_in, 1'b0));
        @(posedge clock);
        #1;
        check("reset_held_idle", dut_vec, expect_ctrl(PH_RESET, ir_in, 1'b0));
        reset   = 1'b0;
        m_phase = PH_FETCH_LO;
        m_z     = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] instr, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, instr);
    endtask

    initial begin
        reset    = 1'b1;
        ir_in    = 16'h0000;
        alu_flag = 4'h0;
        m_phase  = PH_FETCH_LO;
        m_z      = 1'b0;
        #1;
        check("por_idle", dut_vec, expect_ctrl(PH_RESET, ir_in, 1'b0));
        @(posedge clock);
        #1;
        check("por_idle_edge", dut_vec, expect_ctrl(PH_RESET, ir_in, 1'b0));
        reset = 1'b0;

        // Directed instructions: LDI, ADD, SUB, ST, LD, INC, DEC, branches, NOP
        run_instr(16'h042A, 3);   // LDI
        run_instr(16'h3600, 3);   // ADD
        run_instr(16'h4500, 3);   // SUB
        run_instr(16'h2140, 4);   // ST
        run_instr(16'h1C40, 4);   // LD
        run_instr(16'h8800, 3);   // INC
        run_instr(16'h9C00, 3);   // DEC
        run_instr(16'h4000, 3);   // SUB (sets Z from random flags)
        run_instr(16'hB010, 3);   // BEQ
        run_instr(16'hC010, 3);   // BNE
        run_instr(16'hA010, 3);   // BRA
        run_instr(16'hD000, 3);   // NOP

        // HLT then stay halted with all enables off
        run_instr(16'hF000, 3);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0000);
        check("halt_hold", {62'd0, halted, regsel_rf == 4'd0 && regsel_arf == 4'd0 && !IR_enable && !wrMEM},
              64'd3);
        pulse_reset();

        // Reset in the middle of FETCH_H
        cycle(1'b0, 16'h0000);
        for (int i = 0; i < 4 && m_phase != PH_FETCH_HI; i++) cycle(1'b0, 16'h0000);
        check("at_fetch_h", {63'd0, IR_lh}, 64'd1);
        pulse_reset();
        cycle(1'b0, 16'h0000);

        // Randomized run with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0 || (m_phase == PH_HALTED && $urandom_range(0, 9) == 0))
                pulse_reset();
            else
                cycle(1'b0, 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
